// File: rtl/spm_pkg.sv
// spm_pkg: shared state encoding and default sizing for the serial-parallel multiplier driver
package spm_pkg;
   localparam int SPM_WIDTH   = 8;
   localparam int SPM_LAT_DEF = 1;
   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} spm_state_t;
endpackage

// File: rtl/spm_driver.sv
// spm_driver: feeds an external serial-parallel multiplier and collects its serial product
module spm_driver
   import spm_pkg::*;
#(
   parameter int WIDTH   = SPM_WIDTH,
   parameter int SPM_LAT = SPM_LAT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_mc,
   input  logic [WIDTH-1:0]     in_mp,
   output logic [WIDTH-1:0]     spm_x,
   output logic                 spm_y,
   input  logic                 spm_p,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_data
);
   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(PW + SPM_LAT + 1);
   spm_state_t        r_state;
   logic [CW-1:0]     r_cnt;
   logic [WIDTH-1:0]  r_x;
   logic [WIDTH-1:0]  r_mp;
   logic [PW-1:0]     r_acc;
   logic              r_y;
   logic              r_in_ready;
   logic              r_out_valid;
   logic              w_sample;
   logic              w_shift_end;
   logic              w_drain_end;
   // r_mp holds the not-yet-sent multiplier bits; shifting in its MSB sign-extends spm_y
   assign w_sample    = (r_state == SHIFT || r_state == DRAIN) && r_cnt >= CW'(SPM_LAT);
   assign w_shift_end = r_cnt == CW'(PW - 1);
   assign w_drain_end = r_cnt == CW'(PW + SPM_LAT - 1);
   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_data    = r_acc;
   assign spm_x       = r_x;
   assign spm_y       = r_y;
   // Sequencer: serialises the multiplier, counts cycles and collects product bits LSB first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_x         <= '0;
         r_mp        <= '0;
         r_acc       <= '0;
         r_y         <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         if (w_sample) r_acc <= {spm_p, r_acc[PW-1:1]};
         case (r_state)
            IDLE: if (in_valid) begin
               r_x        <= in_mc;
               r_mp       <= {in_mp[WIDTH-1], in_mp[WIDTH-1:1]};
               r_y        <= in_mp[0];
               r_cnt      <= '0;
               r_acc      <= '0;
               r_in_ready <= 1'b0;
               r_state    <= SHIFT;
            end
            SHIFT: begin
               r_cnt <= r_cnt + 1'b1;
               r_mp  <= {r_mp[WIDTH-1], r_mp[WIDTH-1:1]};
               r_y   <= w_shift_end ? 1'b0 : r_mp[0];
               if (w_shift_end) begin
                  r_state     <= (SPM_LAT == 0) ? DONE : DRAIN;
                  r_out_valid <= (SPM_LAT == 0);
               end
            end
            DRAIN: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_drain_end) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spm_driver.sv
// tb_spm_driver: directed checks of spm_driver against a behavioural serial-parallel multiplier
module tb_spm_driver;
   typedef struct {
      logic [7:0]  mc;
      logic [7:0]  mp;
      logic [15:0] p;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [7:0]  in_mc = '0;
   logic [7:0]  in_mp = '0;
   logic        in_ready;
   logic [7:0]  spm_x;
   logic        spm_y;
   logic        spm_p;
   logic        out_valid;
   logic [15:0] out_data;
   int          errs = 0;
   int          checks = 0;
   int          n_acc = 0;
   int          c;
   int          t_nx;
   vec_t        tv[8];
   vec_t        ops[3];

   always #5 clk = ~clk;

   spm_driver #(.WIDTH(8), .SPM_LAT(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_mc(in_mc), .in_mp(in_mp), .spm_x(spm_x), .spm_y(spm_y), .spm_p(spm_p),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   // Behavioural spm: signed partial sum, emits its LSB each cycle and shifts right; cleared on accept
   assign t_nx = c + (spm_y ? int'($signed(spm_x)) : 0);
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         c     <= 0;
         spm_p <= 1'b0;
      end else if (in_valid && in_ready) begin
         c     <= 0;
         spm_p <= 1'b0;
      end else begin
         spm_p <= t_nx[0];
         c     <= t_nx >>> 1;
      end
   end

   always @(posedge clk) if (!rst && in_valid && in_ready) n_acc <= n_acc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_op(input logic [7:0] mc, input logic [7:0] mp, input logic [15:0] exp, input bit keep);
      int lat;
      logic [39:0] yr;
      logic [17:0] ye;
      in_valid = 1'b1;
      in_mc = mc;
      in_mp = mp;
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (!keep) in_valid = 1'b0;
      lat = -1;
      yr = '0;
      for (int n = 0; n < 40; n++) begin
         yr[n] = spm_y;
         if (out_valid) begin
            lat = n;
            break;
         end
         @(negedge clk);
      end
      for (int k = 0; k < 18; k++) ye[k] = (k < 8) ? mp[k] : (k < 16) ? mp[7] : 1'b0;
      chk("latency", lat, 32'd17);
      chk("out_data", {16'd0, out_data}, {16'd0, exp});
      chk("spm_x_hold", {24'd0, spm_x}, {24'd0, mc});
      chk("spm_y_seq", {14'd0, yr[17:0]}, {14'd0, ye});
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("in_ready_after", {31'd0, in_ready}, 32'd1);
      chk("out_valid_after", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      int base;
      tv[0] = '{8'h03, 8'h05, 16'h000F};
      tv[1] = '{8'hFF, 8'hFF, 16'h0001};
      tv[2] = '{8'h80, 8'h80, 16'h4000};
      tv[3] = '{8'h7F, 8'h80, 16'hC080};
      tv[4] = '{8'h05, 8'hFD, 16'hFFF1};
      tv[5] = '{8'h00, 8'h9A, 16'h0000};
      tv[6] = '{8'hFF, 8'h01, 16'hFFFF};
      tv[7] = '{8'h7F, 8'h7F, 16'h3F01};
      ops[0] = '{8'h12, 8'h34, 16'h03A8};
      ops[1] = '{8'hF6, 8'h07, 16'hFFBA};
      ops[2] = '{8'h40, 8'hC0, 16'hF000};
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {16'd0, out_data}, 32'd0);
      chk("rst_spm_x", {24'd0, spm_x}, 32'd0);
      chk("rst_spm_y", {31'd0, spm_y}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      chk("idle_out_ready_in_ready", {31'd0, in_ready}, 32'd1);
      chk("idle_out_ready_out_valid", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         do_op(tv[i].mc, tv[i].mp, tv[i].p, 1'b0);
         consume();
      end
      do_op(8'h03, 8'h05, 16'h000F, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_mc = 8'h11;
         in_mp = 8'h22;
         @(posedge clk);
         @(negedge clk);
         chk("done_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("done_hold_data", {16'd0, out_data}, 32'h000F);
         chk("done_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      consume();
      in_valid = 1'b1;
      in_mc = 8'h55;
      in_mp = 8'h7F;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_rst_spm_y", {31'd0, spm_y}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_out_data", {16'd0, out_data}, 32'd0);
      chk("mid_rst_spm_x", {24'd0, spm_x}, 32'd0);
      chk("mid_rst_spm_y", {31'd0, spm_y}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_op(8'h03, 8'h05, 16'h000F, 1'b0);
      consume();
      base = n_acc;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         do_op(ops[i].mc, ops[i].mp, ops[i].p, 1'b1);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk("stream_accepts", n_acc - base, 32'd3);
      out_ready = 1'b0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/spm_driver.md
SPM_DRIVER -- requirements
Module: spm_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; product is 2*WIDTH bits.
REQ-002 SHALL have parameter SPM_LAT, default 1: cycles from spm_y bit k to product bit k on spm_p.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port in_mc  input  WIDTH  multiplicand, two's complement, parallel operand for the spm.
REQ-008 SHALL have port in_mp  input  WIDTH  multiplier, two's complement, serialised operand.
REQ-009 SHALL have port spm_x  output  WIDTH  parallel operand to the spm array.
REQ-010 SHALL have port spm_y  output  1  serial operand bit to the spm array.
REQ-011 SHALL have port spm_p  input  1  serial product bit from the spm array, LSB first.
REQ-012 SHALL have port out_valid  output  1  product valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts product.
REQ-014 SHALL have port out_data  output  2*WIDTH  signed product in_mc*in_mp.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DRAIN, DONE.
REQ-016 SHALL assert in_ready only in IDLE; accept occurs on an edge where in_valid and in_ready are both high.
REQ-017 SHALL, on accept, register in_mc into spm_x and in_mp into a shift register, clear the cycle counter, and move to SHIFT.
REQ-018 SHALL hold spm_x stable from accept until the next accept; spm_x is not cleared in IDLE or DONE.
REQ-019 SHALL, in SHIFT, drive spm_y in cycle k (k = 0 is the first cycle after accept) as in_mp[k] for k < WIDTH, and as in_mp[WIDTH-1] (sign extension) for WIDTH <= k < 2*WIDTH.
REQ-020 SHALL leave SHIFT for DRAIN after 2*WIDTH cycles, driving spm_y = 0 in DRAIN, DONE and IDLE.
REQ-021 SHALL sample spm_p at the end of cycle k+SPM_LAT as product bit k, for k = 0..2*WIDTH-1, via a right-shifting collector filled from the MSB.
REQ-022 SHALL remain in DRAIN for SPM_LAT cycles, then enter DONE with out_data complete; out_valid SHALL first be high in cycle 2*WIDTH+SPM_LAT (cycle 17 for the defaults).
REQ-023 SHALL hold out_valid and out_data stable in DONE until out_ready is high, then return to IDLE on that edge.
REQ-024 SHALL keep out_valid low in all states except DONE; out_ready outside DONE has no effect.
REQ-025 SHALL ignore in_valid while not in IDLE and SHALL NOT accept a new operand in the same cycle a product is consumed.
REQ-026 SHALL size the cycle counter to ceil(log2(2*WIDTH+SPM_LAT+1)) bits so that it cannot wrap before the exit condition.

Reset
REQ-027 SHALL, on rst high at any time including mid-SHIFT or mid-DRAIN, immediately go to IDLE with in_ready=1, out_valid=0, out_data=0, spm_x=0, spm_y=0, counter=0 and collector=0.
REQ-028 SHALL rely on the spm array sharing rst for flushing its carry-save state; after reset the first accepted operation SHALL produce a correct product.

Structure
REQ-029 SHALL place the state enum and the default WIDTH/SPM_LAT constants in shared package spm_pkg.
REQ-030 SHALL be a single module without sub-modules; the spm array is instantiated by the parent, not inside spm_driver.

Verification (WIDTH=8, SPM_LAT=1, bench models the spm behaviourally)
REQ-031 SHALL cover: mc=3, mp=5 -> out_valid in cycle 17, out_data=0x000F.
REQ-032 SHALL cover: mc=0xFF, mp=0xFF (-1*-1) -> out_data=0x0001; mc=0x80, mp=0x80 -> out_data=0x4000.
REQ-033 SHALL cover: mc=0x7F, mp=0x80 (127*-128) -> out_data=0xC080, with spm_y=1 in cycles 7..15.
REQ-034 SHALL cover: out_ready held low for 5 cycles in DONE -> out_data/out_valid stable, in_ready=0; one cycle after out_ready high -> in_ready=1.
REQ-035 SHALL cover: rst pulsed in SHIFT cycle 6 -> all outputs at reset values at once; then 3*5 -> 0x000F.
REQ-036 SHALL cover: in_valid held high continuously -> exactly one accept per IDLE visit, with no operand lost or duplicated.
